mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter that responds on the processor data bus. It uses the same single-cycle bus protocol as `dmem`: writes commit on the rising clock edge when `we` is high, and reads return data combinationally. The core stores bytes into a small transmit FIFO. The block serialises them onto `txd` as 8N1 frames at a programmable bit period. In `top` it sits beside `dmem`; the `hit` output steers the read-data mux.

## Interface
- `BASE`, default 32'h0000_0080: base address. The block occupies `BASE` to `BASE+0xF`, and `BASE[3:0]` must be 0.
- `DEPTH`, default 4: FIFO depth in bytes. Must be a power of two, at least 2.
- `DIV_RESET`, default 16'd4: value loaded into the divisor register at reset (clocks per bit).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `we`  in  1  bus write enable (`MemWrite`)
- `a`  in  32  bus byte address (`DataAdr`)
- `wd`  in  32  bus write data (`WriteData`)
- `rd`  out  32  read data; combinational; 0 when `hit`=0
- `hit`  out  1  combinational; `a[31:4] == BASE[31:4]`
- `txd`  out  1  serial output; idle high
- `irq`  out  1  registered; high while the FIFO is empty and the FSM is in IDLE

## Operation
- Register decode uses `a[3:2]` while `hit`=1:
  - 0 = DATA
  - 1 = STATUS
  - 2 = DIV
  - 3 = reserved (reads 0, writes ignored)
- DATA:
  - Write pushes `wd[7:0]`.
  - Read returns 0.
- STATUS is read-only except for the overflow clear:
  - bit0 `busy`: FSM not in IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `ovf`: sticky overflow flag.
  - bits[7:4]: FIFO count.
  - Other bits read 0.
  - Any write to STATUS clears `ovf`.
- DIV:
  - Read/write; 16 bits in `wd[15:0]`; reads are zero-extended.
  - A value of 0 behaves as 1.
- FIFO push rules:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set.
  - Pointers wrap modulo `DEPTH`.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The FIFO is popped into an 8-bit shift register on that edge.
  - START drives `txd`=0 for one bit period, then goes to DATA.
  - DATA sends 8 bits, LSB first, one bit period each, then goes to STOP.
  - STOP drives `txd`=1 for one bit period.
  - From STOP: go to START with a pop if the FIFO is non-empty, otherwise go to IDLE. Back-to-back frames have no idle gap.
- Bit period:
  - A down-counter is loaded from `max(DIV,1)-1` at every bit start.
  - The bit ends on the edge at which the counter equals 0.
  - A DIV write takes effect at the next bit start; the current bit is not stretched.
- `txd` is registered and driven directly from FSM and shift-register state.

## Timing
- Reset values:
  - `txd`=1, `irq`=1, FSM in IDLE.
  - FIFO empty, `ovf`=0, DIV=`DIV_RESET`, bit counter 0.
  - `rd` and `hit` are combinational and follow `a`.
- Reset mid-frame: `txd` returns to 1 on the reset edge, the frame is abandoned, and the FIFO contents are discarded.
- Latency:
  - A DATA write at edge N makes the FIFO non-empty after N.
  - If the FSM is IDLE, it pops at edge N+1, and `txd` falls after N+1.
  - The start bit lasts exactly DIV clocks.
- Frame length is 10×DIV clocks (11×DIV with parity).
- `irq` deasserts the cycle after edge N and reasserts on the edge at which STOP→IDLE occurs.
- STATUS read in the same cycle as a write shows pre-edge values.

## Configuration
- `UART_TX_PARITY_EN`: adds a PARITY state between DATA and STOP.
  - The parity bit is even parity: XOR of the 8 data bits, lasting one bit period.
  - STATUS bit8 reads 1 when the macro is defined.
- Without the macro: no PARITY state, 10-bit frames, and STATUS bit8 reads 0.

## Test plan
- After reset, read `BASE+4` → 0x0000_0004 (empty). Read `BASE+8` → 4. `txd`=1 and `irq`=1.
- With DIV=4, write 0xA5 to `BASE` → `txd` sequence, 4 clocks each bit: 0,1,0,1,0,0,1,0,1,1. STATUS bit0 is high during the frame. `irq` returns high at the end of the frame.
- Write 0x55, 0x0F, 0xF0, 0x33, 0x44, 0x66 on consecutive cycles with DIV=4, DEPTH=4:
  - The first pops immediately, the next four fill the FIFO, and the sixth is dropped with `ovf`=1.
  - Five frames then go out back-to-back with no idle bits.
  - A write to STATUS clears `ovf`.
- Write DIV=0 then 0x01 → each bit lasts 1 clock and the frame is 10 clocks. A DIV=8 write mid-frame lengthens only subsequent bits.
- Assert `reset` during DATA bit 3 → `txd`=1 next cycle, STATUS=0x4, no further transitions.
- Reads outside `BASE..BASE+0xF` (e.g. `a`=0x60) → `hit`=0, `rd`=0. A `we` at that address leaves the FIFO unchanged.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers in front of a small byte FIFO.
// Latency: a DATA write at edge N pops at N+1 when idle, and txd falls after N+1.
// Backpressure: none; a push into a full FIFO is dropped and sets the sticky ovf flag. UART_TX_PARITY_EN adds an even-parity bit.
module mmio_uart_tx #(
   parameter logic [31:0] BASE      = 32'h0000_0080,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] DIV_RESET = 16'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        hit,
   output logic        txd,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   fcount, fcount_nxt;
   logic          ovf;
   logic [15:0]   div, div_m1, bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg, shreg_nxt;
   logic          par;
   logic [1:0]    sel;
   logic          fifo_empty, fifo_full, wr_data, wr_stat, wr_div;
   logic          pop, push, busy, bit_done, bit_start, txd_nxt;
   logic [31:0]   status, cnt_ext;
   logic          unused_bits;

   assign hit        = (a[31:4] == BASE[31:4]);
   assign sel        = a[3:2];
   assign wr_data    = we && hit && (sel == 2'd0);
   assign wr_stat    = we && hit && (sel == 2'd1);
   assign wr_div     = we && hit && (sel == 2'd2);
   assign fifo_empty = (fcount == '0);
   assign fifo_full  = (fcount == DEPTH_C);
   assign busy       = (state != S_IDLE);
   assign bit_done   = busy && (bit_cnt == 16'd0);
   assign div_m1     = (div == 16'd0) ? 16'd0 : div - 16'd1;

   // Frames chain straight from STOP into the next START, so a pop can also happen there.
   assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
   assign push       = wr_data && (!fifo_full || pop);
   assign fcount_nxt = fcount + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   assign cnt_ext     = 32'(fcount);
   assign unused_bits = ^{wd[31:16], a[1:0], cnt_ext[31:4]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         txd     <= 1'b1;
         irq     <= 1'b1;
         wp      <= '0;
         rp      <= '0;
         fcount  <= '0;
         ovf     <= 1'b0;
         div     <= DIV_RESET;
         bit_cnt <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         par     <= 1'b0;
      end else begin
         state  <= state_nxt;
         txd    <= txd_nxt;
         irq    <= (state_nxt == S_IDLE) && (fcount_nxt == '0);
         fcount <= fcount_nxt;
         shreg  <= shreg_nxt;
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp  <= rp + 1'b1;
            par <= ^mem[rp];
         end
         if (wr_stat) ovf <= 1'b0;
         else if (wr_data && !push) ovf <= 1'b1;
         if (wr_div) div <= wd[15:0];
         // The divisor is sampled only at a bit start, so a DIV write never stretches the current bit.
         if (bit_start) bit_cnt <= div_m1;
         else if (busy && !bit_done) bit_cnt <= bit_cnt - 16'd1;
         if (state != S_DATA) bit_idx <= 3'd0;
         else if (bit_done) bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wd[7:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!fifo_empty) state_nxt = S_START;
         S_START:  if (bit_done) state_nxt = S_DATA;
         S_DATA:   if (bit_done && (bit_idx == 3'd7))
`ifdef UART_TX_PARITY_EN
                      state_nxt = S_PARITY;
`else
                      state_nxt = S_STOP;
`endif
         S_PARITY: if (bit_done) state_nxt = S_STOP;
         S_STOP:   if (bit_done) state_nxt = fifo_empty ? S_IDLE : S_START;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // txd is registered from the post-edge state so it lines up with the bit the FSM enters.
   always_comb begin
      shreg_nxt = shreg;
      if (pop) shreg_nxt = mem[rp];
      else if ((state == S_DATA) && bit_done) shreg_nxt = {1'b0, shreg[7:1]};
      bit_start = (state_nxt != S_IDLE) && ((state == S_IDLE) || bit_done);
      txd_nxt = 1'b1;
      case (state_nxt)
         S_START:  txd_nxt = 1'b0;
         S_DATA:   txd_nxt = shreg_nxt[0];
         S_PARITY: txd_nxt = par;
         default:  txd_nxt = 1'b1;
      endcase
   end

   always_comb begin
      status      = '0;
      status[0]   = busy;
      status[1]   = fifo_full;
      status[2]   = fifo_empty;
      status[3]   = ovf;
      status[7:4] = cnt_ext[3:0];
`ifdef UART_TX_PARITY_EN
      status[8]   = 1'b1;
`endif
      rd = '0;
      if (hit) begin
         case (sel)
            2'd1:    rd = status;
            2'd2:    rd = {16'h0000, div};
            default: rd = '0;
         endcase
      end
   end
endmodule
